window_gen_3x3: RTL and testbench
=================================

Name: window_gen_3x3

Overview:
Upstream neighbour of the 3x3 edge/filter stages. It accepts a raster-order pixel stream, one pixel per valid cycle. It buffers the two previous image lines and presents a 3x3 neighbourhood on nine tap outputs, with a qualifying valid. Taps feed the in1..in9 inputs of the filter functions; win_valid drives their enable.

Parameters:
DATA_WIDTH, 8, pixel width in bits
IMG_WIDTH, 640, pixels per line (>=3)
IMG_HEIGHT, 480, lines per frame (>=3)
CNT_WIDTH, 10, width of the column and row counters; must hold max(IMG_WIDTH, IMG_HEIGHT)-1

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
pix_in  in  DATA_WIDTH  incoming pixel
pix_valid  in  1  pix_in accepted this cycle; no backpressure
sof  in  1  start of frame; only meaningful with pix_valid=1
win1..win9  out  DATA_WIDTH each  window taps. win1..3 = top row (line r-2), win4..6 = middle row (r-1), win7..9 = bottom row (current line r). Within each row, left to right is columns c-2, c-1, c.
win_valid  out  1  taps hold a complete in-frame window
frame_done  out  1  one-cycle pulse after the last pixel of a frame
col_cnt  out  CNT_WIDTH  column of the next expected pixel (debug)
row_cnt  out  CNT_WIDTH  row of the next expected pixel (debug)

Behaviour:
- Reset (async):
  - win1..win9, win_valid, frame_done, col_cnt and row_cnt all go to 0.
  - Line-buffer contents are undefined; they are never exposed because win_valid gates them.
- Storage:
  - Two line buffers, LB1 and LB2, each IMG_WIDTH deep and addressed by column.
  - LB1[c] holds line r-1; LB2[c] holds line r-2.
  - On an accepted pixel at column c: LB2[c] <= old LB1[c] and LB1[c] <= pix_in, in the same cycle.
  - Behavioural or inferred RAM are both allowed. The tap timing below is mandatory.
- Taps, updated only on cycles with pix_valid=1:
  - Each row shifts left: win1<=win2, win2<=win3, win4<=win5, win5<=win6, win7<=win8, win8<=win9.
  - New column: win3<=LB2[c], win6<=LB1[c], win9<=pix_in.
  - When pix_valid=0, taps, counters and win_valid hold their values. frame_done goes to 0.
- Latency: taps and win_valid reflect the pixel accepted on edge N from edge N onward, i.e. one cycle after the input.
- win_valid is registered. On each accept it is set to 1 if the accepted pixel had row>=2 and col>=2, otherwise 0.
  - Windows that straddle a line wrap (col 0/1) or cover rows 0/1 are never flagged valid.
  - Valid windows per frame = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- Counters:
  - On accept, col increments.
  - At col=IMG_WIDTH-1, col wraps to 0 and row increments.
  - At row=IMG_HEIGHT-1 with col=IMG_WIDTH-1, both go to 0 and frame_done pulses high for one cycle, coincident with the final win_valid.
- sof:
  - An accept with sof=1 treats that pixel as (0,0) regardless of the counters; it is written to LB1[0].
  - The next expected position becomes (0,1).
  - That accept sets win_valid to 0.
  - Any partial frame in progress is abandoned, with no frame_done.
- Back-to-back frames: after wrap, the next pixel is (0,0) even without sof. The first valid window of the new frame again needs row 2, col 2, so stale LB data is never flagged valid.
- Reset mid-frame: everything returns to reset values immediately, and the next accepted pixel is (0,0).
- Arithmetic: counters are unsigned CNT_WIDTH, and comparisons are against IMG_WIDTH-1 and IMG_HEIGHT-1. No pixel arithmetic is done in this block.

Test Plan:
Setup for all scenarios unless stated otherwise: IMG_WIDTH=4, IMG_HEIGHT=4, pixel(r,c)=4r+c+1, stream 1..16.
- Continuous stream:
  - First win_valid=1 the cycle after pixel 11, with taps 1,2,3,5,6,7,9,10,11.
  - Next valid window is 2,3,4,6,7,8,10,11,12.
  - Exactly 4 valid cycles; frame_done pulses once, after pixel 16, with taps 6,7,8,10,11,12,14,15,16.
- Random pix_valid gaps (about 50% idle): identical tap sequence on the valid cycles; outputs hold during idle cycles.
- Two frames back-to-back without sof: second frame yields the same 4 windows. Frame 2's first valid window is 1,2,3,5,6,7,9,10,11, containing no frame-1 data.
- sof asserted on pixel 7 of frame 1:
  - No frame_done for the abandoned frame.
  - That pixel is treated as (0,0) and col_cnt reads 1 afterwards.
  - First valid window comes 10 accepts later.
- Reset asserted mid-frame after pixel 9: all outputs are 0 asynchronously; a fresh 1..16 stream then reproduces scenario 1 exactly.
- IMG_WIDTH=3, IMG_HEIGHT=3 corner: a single valid window 1..9 and frame_done on the same cycle.

Source files
------------

// File: rtl/window_gen_3x3.sv
`default_nettype none
// ============================================================================
//  Module      : window_gen_3x3
//  Description : Builds a 3x3 neighbourhood from a raster-order pixel stream
//                using two line buffers, for the downstream 3x3 filter stages.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           clock, all state on rising edge
//    rst           asynchronous active-high reset
//    pix_in_i      incoming pixel
//    pix_valid_i   pixel accepted this cycle (no backpressure)
//    sof_i         start of frame, qualified by pix_valid_i
//    win1_o..3_o   top row    (line r-2), columns c-2, c-1, c
//    win4_o..6_o   middle row (line r-1), columns c-2, c-1, c
//    win7_o..9_o   bottom row (line r),   columns c-2, c-1, c
//    win_valid_o   taps hold a complete in-frame window
//    frame_done_o  one-cycle pulse after the last pixel of a frame
//    col_cnt_o     column of the next expected pixel
//    row_cnt_o     row of the next expected pixel
// ============================================================================
module window_gen_3x3 #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pix_in_i,
    input  logic                  pix_valid_i,
    input  logic                  sof_i,
    output logic [DATA_WIDTH-1:0] win1_o,
    output logic [DATA_WIDTH-1:0] win2_o,
    output logic [DATA_WIDTH-1:0] win3_o,
    output logic [DATA_WIDTH-1:0] win4_o,
    output logic [DATA_WIDTH-1:0] win5_o,
    output logic [DATA_WIDTH-1:0] win6_o,
    output logic [DATA_WIDTH-1:0] win7_o,
    output logic [DATA_WIDTH-1:0] win8_o,
    output logic [DATA_WIDTH-1:0] win9_o,
    output logic                  win_valid_o,
    output logic                  frame_done_o,
    output logic [CNT_WIDTH-1:0]  col_cnt_o,
    output logic [CNT_WIDTH-1:0]  row_cnt_o
);

    localparam int ADDR_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    localparam logic [CNT_WIDTH-1:0] c_last_col = CNT_WIDTH'(IMG_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] c_last_row = CNT_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [CNT_WIDTH-1:0] c_two      = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] c_one      = CNT_WIDTH'(1);

    // Line buffers: lb1 holds line r-1, lb2 holds line r-2, indexed by column.
    logic [DATA_WIDTH-1:0] lb1_q [0:IMG_WIDTH-1];
    logic [DATA_WIDTH-1:0] lb2_q [0:IMG_WIDTH-1];

    // Tap registers, index 0..8 map to win1..win9.
    logic [DATA_WIDTH-1:0] win_q [0:8];

    logic [CNT_WIDTH-1:0] col_q, col_d;
    logic [CNT_WIDTH-1:0] row_q, row_d;
    logic                 win_valid_q, win_valid_d;
    logic                 frame_done_q, frame_done_d;

    logic [CNT_WIDTH-1:0] w_col_eff;
    logic [CNT_WIDTH-1:0] w_row_eff;
    logic                 w_col_last;
    logic                 w_row_last;
    logic [ADDR_W-1:0]    w_addr;

    // sof forces the accepted pixel to position (0,0) whatever the counters
    // say, so every decision below works on the effective position.
    always_comb begin
        w_col_eff    = sof_i ? '0 : col_q;
        w_row_eff    = sof_i ? '0 : row_q;
        w_col_last   = (w_col_eff == c_last_col);
        w_row_last   = (w_row_eff == c_last_row);
        w_addr       = w_col_eff[ADDR_W-1:0];

        col_d        = w_col_last ? '0 : (w_col_eff + c_one);
        row_d        = w_row_eff;
        if (w_col_last) begin
            row_d = w_row_last ? '0 : (w_row_eff + c_one);
        end

        win_valid_d  = (w_row_eff >= c_two) && (w_col_eff >= c_two);
        frame_done_d = w_col_last && w_row_last;
    end

    // Line-buffer storage carries no reset; stale contents are never flagged
    // valid because a valid window needs two fresh lines of the current frame.
    always_ff @(posedge clk) begin
        if (pix_valid_i) begin
            lb2_q[w_addr] <= lb1_q[w_addr];
            lb1_q[w_addr] <= pix_in_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else if (pix_valid_i) begin
            // Each row shifts left; the new right-hand column enters from
            // line r-2, line r-1 and the live pixel respectively.
            win_q[0]     <= win_q[1];
            win_q[1]     <= win_q[2];
            win_q[2]     <= lb2_q[w_addr];
            win_q[3]     <= win_q[4];
            win_q[4]     <= win_q[5];
            win_q[5]     <= lb1_q[w_addr];
            win_q[6]     <= win_q[7];
            win_q[7]     <= win_q[8];
            win_q[8]     <= pix_in_i;
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end else begin
            frame_done_q <= 1'b0;
        end
    end

    assign win1_o       = win_q[0];
    assign win2_o       = win_q[1];
    assign win3_o       = win_q[2];
    assign win4_o       = win_q[3];
    assign win5_o       = win_q[4];
    assign win6_o       = win_q[5];
    assign win7_o       = win_q[6];
    assign win8_o       = win_q[7];
    assign win9_o       = win_q[8];
    assign win_valid_o  = win_valid_q;
    assign frame_done_o = frame_done_q;
    assign col_cnt_o    = col_q;
    assign row_cnt_o    = row_q;

endmodule
`default_nettype wire

// File: tb/tb_window_gen_3x3.sv
`default_nettype none
// ============================================================================
//  Module      : tb_window_gen_3x3
//  Description : Directed self-checking bench for window_gen_3x3 with a 4x4
//                image (pixel(r,c) = 4r+c+1) and a 3x3 corner instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_window_gen_3x3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // ---------------- 4x4 instance ----------------
    logic [7:0] pix_a;
    logic       pv_a, sof_a;
    logic [7:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
    logic       val_a, fd_a;
    logic [9:0] col_a, row_a;
    logic [71:0] taps_a;
    assign taps_a = {a1, a2, a3, a4, a5, a6, a7, a8, a9};

    window_gen_3x3 #(
        .DATA_WIDTH (8),
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (4),
        .CNT_WIDTH  (10)
    ) u_dut_a (
        .clk          (clk),
        .rst          (rst),
        .pix_in_i     (pix_a),
        .pix_valid_i  (pv_a),
        .sof_i        (sof_a),
        .win1_o       (a1),
        .win2_o       (a2),
        .win3_o       (a3),
        .win4_o       (a4),
        .win5_o       (a5),
        .win6_o       (a6),
        .win7_o       (a7),
        .win8_o       (a8),
        .win9_o       (a9),
        .win_valid_o  (val_a),
        .frame_done_o (fd_a),
        .col_cnt_o    (col_a),
        .row_cnt_o    (row_a)
    );

    // ---------------- 3x3 corner instance ----------------
    logic [7:0] pix_b;
    logic       pv_b, sof_b;
    logic [7:0] b1, b2, b3, b4, b5, b6, b7, b8, b9;
    logic       val_b, fd_b;
    logic [9:0] col_b, row_b;
    logic [71:0] taps_b;
    assign taps_b = {b1, b2, b3, b4, b5, b6, b7, b8, b9};

    window_gen_3x3 #(
        .DATA_WIDTH (8),
        .IMG_WIDTH  (3),
        .IMG_HEIGHT (3),
        .CNT_WIDTH  (10)
    ) u_dut_b (
        .clk          (clk),
        .rst          (rst),
        .pix_in_i     (pix_b),
        .pix_valid_i  (pv_b),
        .sof_i        (sof_b),
        .win1_o       (b1),
        .win2_o       (b2),
        .win3_o       (b3),
        .win4_o       (b4),
        .win5_o       (b5),
        .win6_o       (b6),
        .win7_o       (b7),
        .win8_o       (b8),
        .win9_o       (b9),
        .win_valid_o  (val_b),
        .frame_done_o (fd_b),
        .col_cnt_o    (col_b),
        .row_cnt_o    (row_b)
    );

    int checks = 0;
    int errors = 0;
    int vcount;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-computed windows of the 4x4 image, keyed by the pixel that
    // completes them.
    function automatic logic [71:0] exp_taps(input int p);
        case (p)
            11:      return 72'h01_02_03_05_06_07_09_0A_0B;
            12:      return 72'h02_03_04_06_07_08_0A_0B_0C;
            15:      return 72'h05_06_07_09_0A_0B_0D_0E_0F;
            16:      return 72'h06_07_08_0A_0B_0C_0E_0F_10;
            default: return 72'h0;
        endcase
    endfunction

    function automatic logic exp_valid(input int p);
        return (p == 11) || (p == 12) || (p == 15) || (p == 16);
    endfunction

    task automatic accept_a(input int p, input logic s);
        pix_a = 8'(p);
        pv_a  = 1'b1;
        sof_a = s;
        @(posedge clk);
        #1;
        pv_a  = 1'b0;
        sof_a = 1'b0;
    endtask

    task automatic check_after(input int p);
        chk($sformatf("valid_p%0d", p), {71'b0, val_a}, {71'b0, exp_valid(p)});
        chk($sformatf("fdone_p%0d", p), {71'b0, fd_a}, {71'b0, p == 16});
        chk($sformatf("col_p%0d", p), {62'b0, col_a}, 72'(p % 4));
        chk($sformatf("row_p%0d", p), {62'b0, row_a}, 72'((p / 4) % 4));
        if (exp_valid(p)) begin
            vcount++;
            chk($sformatf("taps_p%0d", p), taps_a, exp_taps(p));
        end
    endtask

    task automatic check_idle(input int p);
        chk($sformatf("hold_valid_p%0d", p), {71'b0, val_a}, {71'b0, exp_valid(p)});
        chk($sformatf("idle_fdone_p%0d", p), {71'b0, fd_a}, 72'h0);
        chk($sformatf("hold_col_p%0d", p), {62'b0, col_a}, 72'(p % 4));
        if (exp_valid(p)) begin
            chk($sformatf("hold_taps_p%0d", p), taps_a, exp_taps(p));
        end
    endtask

    task automatic stream(input bit gaps, input bit sof_first);
        vcount = 0;
        for (int p = 1; p <= 16; p++) begin
            accept_a(p, sof_first && (p == 1));
            check_after(p);
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                    check_idle(p);
                end
            end
        end
        chk("valid_count", 72'(vcount), 72'd4);
    endtask

    task automatic check_reset_a(input string tag);
        chk({tag, "_taps"}, taps_a, 72'h0);
        chk({tag, "_valid"}, {71'b0, val_a}, 72'h0);
        chk({tag, "_fdone"}, {71'b0, fd_a}, 72'h0);
        chk({tag, "_col"}, {62'b0, col_a}, 72'h0);
        chk({tag, "_row"}, {62'b0, row_a}, 72'h0);
    endtask

    initial begin
        rst   = 1'b1;
        pix_a = '0; pv_a = 1'b0; sof_a = 1'b0;
        pix_b = '0; pv_b = 1'b0; sof_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_a("reset");
        chk("reset_b_valid", {71'b0, val_b}, 72'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Continuous stream
        stream(1'b0, 1'b0);

        // Random idle gaps
        stream(1'b1, 1'b0);

        // Two frames back-to-back without sof
        stream(1'b0, 1'b0);
        stream(1'b0, 1'b0);

        // sof on the 7th pixel: frame abandoned, restart from (0,0)
        for (int p = 1; p <= 6; p++) begin
            accept_a(p, 1'b0);
            check_after(p);
        end
        stream(1'b0, 1'b1);

        // Reset mid-frame after pixel 9, observed before the next clock edge
        for (int p = 1; p <= 9; p++) begin
            accept_a(p, 1'b0);
            check_after(p);
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_a("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        stream(1'b0, 1'b0);

        // 3x3 corner: single window 1..9 with frame_done on the same cycle
        for (int p = 1; p <= 9; p++) begin
            pix_b = 8'(p);
            pv_b  = 1'b1;
            @(posedge clk);
            #1;
            pv_b  = 1'b0;
            chk($sformatf("b_valid_p%0d", p), {71'b0, val_b}, {71'b0, p == 9});
            chk($sformatf("b_fdone_p%0d", p), {71'b0, fd_b}, {71'b0, p == 9});
            if (p == 9) begin
                chk("b_taps", taps_b, 72'h01_02_03_04_05_06_07_08_09);
                chk("b_col_wrap", {62'b0, col_b}, 72'h0);
                chk("b_row_wrap", {62'b0, row_b}, 72'h0);
            end
        end
        @(posedge clk);
        #1;
        chk("b_fdone_pulse_end", {71'b0, fd_b}, 72'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
